// File: rtl/bitstream_decimator.sv
// Sinc1 decimator for a 1-bit delta-sigma stream: synchronizes the sample clock and data bit,
// accumulates ones over OSR samples and offers each conversion on a valid/ready handshake.
module bitstream_decimator #(
    parameter int OSR          = 256,
    parameter int RESULT_WIDTH = 9,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sampleClock,
    input  logic                    bitIn,
    input  logic                    enable,
    output logic                    feedbackOut,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    resultValid,
    input  logic                    resultReady,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(OSR - 1);

    logic [SYNC_STAGES-1:0]  r_clkSync;
    logic [SYNC_STAGES-1:0]  r_bitSync;
    logic                    r_clkHist;
    logic [CNT_W-1:0]        r_sampleCount;
    logic [RESULT_WIDTH-1:0] r_onesCount;

    logic                    w_samplePulse;
    logic                    w_bitSync;
    logic                    w_take;
    logic                    w_dump;
    logic                    w_slotFree;
    logic                    w_load;
    logic                    w_transfer;
    logic [RESULT_WIDTH-1:0] w_bitExt;
    logic [RESULT_WIDTH-1:0] w_final;

    // sampleClock and bitIn share the same depth so the bit lines up with its own edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clkSync <= '0;
            r_bitSync <= '0;
            r_clkHist <= 1'b0;
        end else begin
            r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], sampleClock};
            r_bitSync <= {r_bitSync[SYNC_STAGES-2:0], bitIn};
            r_clkHist <= r_clkSync[SYNC_STAGES-1];
        end
    end

    assign w_samplePulse = r_clkSync[SYNC_STAGES-1] & ~r_clkHist;
    assign w_bitSync     = r_bitSync[SYNC_STAGES-1];
    assign w_bitExt      = {{(RESULT_WIDTH-1){1'b0}}, w_bitSync};
    assign w_final       = r_onesCount + w_bitExt;
    assign w_take        = enable & w_samplePulse;
    assign w_dump        = w_take & (r_sampleCount == LAST_SAMPLE);
    assign w_transfer    = resultValid & resultReady;
    assign w_slotFree    = ~resultValid | resultReady;
    assign w_load        = w_dump & w_slotFree;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sampleCount <= '0;
            r_onesCount   <= '0;
            feedbackOut   <= 1'b0;
            overrun       <= 1'b0;
        end else if (!enable) begin
            r_sampleCount <= '0;
            r_onesCount   <= '0;
            overrun       <= 1'b0;
        end else if (w_take) begin
            feedbackOut <= w_bitSync;
            if (w_dump) begin
                r_sampleCount <= '0;
                r_onesCount   <= '0;
                if (!w_slotFree) begin
                    overrun <= 1'b1;
                end
            end else begin
                r_sampleCount <= r_sampleCount + CNT_W'(1);
                r_onesCount   <= w_final;
            end
        end
    end

    // A dump landing on a transfer cycle replaces the result and keeps valid asserted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result      <= '0;
            resultValid <= 1'b0;
        end else if (w_load) begin
            result      <= w_final;
            resultValid <= 1'b1;
        end else if (w_transfer) begin
            resultValid <= 1'b0;
        end
    end

endmodule
